// File: rtl/uart_rx_frame_check_if.sv
// Bundles the receive-side signals of uart_rx_frame_check.
//   master : bit sampler / control side (drives enable, strobe, parity setup)
//   slave  : frame checker (drives data, result pulses and busy)
// Signals:
//   rx_enable, bit_valid, sampled_bit, par_en, par_typ  -> into the checker
//   p_data, frame_done, data_valid, start_error,
//   parity_error, stop_error, busy                       <- from the checker
interface uart_rx_frame_check_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_enable;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  frame_done;
  logic                  data_valid;
  logic                  start_error;
  logic                  parity_error;
  logic                  stop_error;
  logic                  busy;

  modport master (
    output rx_enable, bit_valid, sampled_bit, par_en, par_typ,
    input  p_data, frame_done, data_valid, start_error, parity_error,
           stop_error, busy
  );

  modport slave (
    input  rx_enable, bit_valid, sampled_bit, par_en, par_typ,
    output p_data, frame_done, data_valid, start_error, parity_error,
           stop_error, busy
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker. Consumes one majority-voted line sample per
// bit_valid strobe and walks start / data (LSB first) / optional parity /
// 1..2 stop bits. Reports each frame with single-cycle result pulses.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      uart_rx_frame_check_if.slave (see interface file for signals)
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   STOP_BITS   stop bits per frame (1 or 2)
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  uart_rx_frame_check_if.slave        bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  // stop_cnt value on which a good stop bit completes the frame
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_stop_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_acc;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_fail;

  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_frame_done;
  logic                  r_data_valid;
  logic                  r_start_error;
  logic                  r_parity_error;
  logic                  r_stop_error;
  logic                  r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_stop_cnt     <= 1'b0;
      r_shift        <= '0;
      r_par_acc      <= 1'b0;
      r_par_en       <= 1'b0;
      r_par_typ      <= 1'b0;
      r_par_fail     <= 1'b0;
      r_p_data       <= '0;
      r_frame_done   <= 1'b0;
      r_data_valid   <= 1'b0;
      r_start_error  <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      // Result flags are pulses: cleared every cycle unless set below.
      r_frame_done   <= 1'b0;
      r_data_valid   <= 1'b0;
      r_start_error  <= 1'b0;
      r_parity_error <= 1'b0;
      r_stop_error   <= 1'b0;

      // Disable takes priority over a coincident strobe and drops any
      // frame in flight without touching P_DATA or producing pulses.
      if (!bus.rx_enable) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else if (bus.bit_valid) begin
        case (r_state)
          IDLE: begin
            if (!bus.sampled_bit) begin
              r_state    <= DATA;
              r_busy     <= 1'b1;
              r_par_en   <= bus.par_en;
              r_par_typ  <= bus.par_typ;
              r_shift    <= '0;
              r_par_acc  <= 1'b0;
              r_par_fail <= 1'b0;
              r_bit_cnt  <= '0;
              r_stop_cnt <= 1'b0;
            end else begin
              r_start_error <= 1'b1;
            end
          end

          DATA: begin
            r_shift[r_bit_cnt] <= bus.sampled_bit;
            r_par_acc          <= r_par_acc ^ bus.sampled_bit;
            r_bit_cnt          <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_BIT)
              r_state <= r_par_en ? PARITY : STOP;
          end

          PARITY: begin
            // Expected bit makes the total XOR equal PAR_TYP (0 even, 1 odd).
            if (bus.sampled_bit != (r_par_acc ^ r_par_typ))
              r_par_fail <= 1'b1;
            r_state <= STOP;
          end

          STOP: begin
            // A low stop sample ends the frame at once, even mid two-stop.
            if (!bus.sampled_bit || (r_stop_cnt == STOP_LAST)) begin
              r_state        <= IDLE;
              r_busy         <= 1'b0;
              r_frame_done   <= 1'b1;
              r_p_data       <= r_shift;
              r_parity_error <= r_par_fail;
              r_stop_error   <= ~bus.sampled_bit;
              r_data_valid   <= ~r_par_fail & bus.sampled_bit;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.p_data       = r_p_data;
  assign bus.frame_done   = r_frame_done;
  assign bus.data_valid   = r_data_valid;
  assign bus.start_error  = r_start_error;
  assign bus.parity_error = r_parity_error;
  assign bus.stop_error   = r_stop_error;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: one instance with one stop bit, one with
// two; stimulus is routed to the selected instance and results are compared
// against frame-level expectations computed from the data that was sent.
module tb_uart_rx_frame_check;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic en, bv, sb, pe, pt;
  bit   sel;  // 0: STOP_BITS=1 instance, 1: STOP_BITS=2 instance

  uart_rx_frame_check_if #(.DATA_WIDTH(8)) bus0 ();
  uart_rx_frame_check_if #(.DATA_WIDTH(8)) bus1 ();

  assign bus0.rx_enable   = en;
  assign bus0.bit_valid   = bv & ~sel;
  assign bus0.sampled_bit = sb;
  assign bus0.par_en      = pe;
  assign bus0.par_typ     = pt;
  assign bus1.rx_enable   = en;
  assign bus1.bit_valid   = bv & sel;
  assign bus1.sampled_bit = sb;
  assign bus1.par_en      = pe;
  assign bus1.par_typ     = pt;

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

  logic [7:0] o_pd;
  logic o_fd, o_dv, o_se, o_pe, o_ste, o_busy;
  assign o_pd   = sel ? bus1.p_data       : bus0.p_data;
  assign o_fd   = sel ? bus1.frame_done   : bus0.frame_done;
  assign o_dv   = sel ? bus1.data_valid   : bus0.data_valid;
  assign o_se   = sel ? bus1.start_error  : bus0.start_error;
  assign o_pe   = sel ? bus1.parity_error : bus0.parity_error;
  assign o_ste  = sel ? bus1.stop_error   : bus0.stop_error;
  assign o_busy = sel ? bus1.busy         : bus0.busy;

  int n_chk = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  logic [7:0] last_pd [2];

  always @(posedge clk) if (o_fd) fd_cnt <= fd_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one strobe; return #1 after the edge that consumed it.
  task automatic strobe(input logic b);
    bv = 1'b1; sb = b;
    @(posedge clk); #1;
    bv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic gap(input bit gaps);
    if (gaps && ($urandom_range(0, 3) == 0)) idle(1);
  endtask

  // Send a complete frame to the selected instance and check its outcome.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic pbit, input logic s0, input logic s1,
                            input bit gaps);
    int   nstop;
    logic perr, serr;
    nstop = sel ? 2 : 1;
    pe = pen; pt = ptyp;
    strobe(1'b0);
    check("busy_rise", o_busy, 1);
    // Parity setup changes after start acceptance must be ignored.
    pe = 1'($urandom); pt = 1'($urandom);
    for (int i = 0; i < 8; i++) begin gap(gaps); strobe(d[i]); end
    if (pen) begin gap(gaps); strobe(pbit); end
    gap(gaps); strobe(s0);
    if (s0 && nstop == 2) begin
      check("no_done_mid_stop", o_fd, 0);
      gap(gaps); strobe(s1);
    end
    perr = pen && (pbit != ((^d) ^ ptyp));
    serr = !s0 || (nstop == 2 && !s1);
    check("frame_done", o_fd, 1);
    check("data_valid", o_dv, !perr && !serr);
    check("parity_error", o_pe, perr);
    check("stop_error", o_ste, serr);
    check("p_data", o_pd, d);
    check("busy_fall", o_busy, 0);
    last_pd[sel] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fd0;
    en = 1'b1; bv = 1'b0; sb = 1'b1; pe = 1'b0; pt = 1'b0; sel = 1'b0;
    last_pd[0] = 8'h00; last_pd[1] = 8'h00;
    idle(2);
    // Reset state
    check("rst_p_data", o_pd, 0);
    check("rst_frame_done", o_fd, 0);
    check("rst_data_valid", o_dv, 0);
    check("rst_busy", o_busy, 0);
    check("rst_errors", {o_se, o_pe, o_ste}, 0);
    rst_n = 1'b1;
    idle(2);

    // 8N1 0xA5
    send_frame(8'hA5, 0, 0, 0, 1, 1, 0);
    idle(1);
    check("done_one_cycle", o_fd, 0);
    check("p_data_hold", o_pd, 8'hA5);

    // 8E1 0x03 with wrong parity, then odd with parity bit 1 (clean)
    send_frame(8'h03, 1, 0, 1, 1, 1, 0);
    send_frame(8'h03, 1, 1, 1, 1, 1, 0);

    // False start then a good frame
    strobe(1'b1);
    check("false_start_err", o_se, 1);
    check("false_start_busy", o_busy, 0);
    idle(1);
    check("start_err_one_cycle", o_se, 0);
    send_frame(8'h3C, 0, 0, 0, 1, 1, 0);

    // Two stop bits: first stop low ends frame; next strobe seen in IDLE
    sel = 1'b1;
    send_frame(8'h5A, 0, 0, 0, 0, 1, 0);
    strobe(1'b1);
    check("stop2_second_is_idle", o_se, 1);
    check("stop2_no_second_done", o_fd, 0);
    send_frame(8'hC3, 0, 0, 0, 1, 1, 0);
    send_frame(8'h96, 1, 0, 0, 1, 0, 0);

    // Abandoned frame
    sel = 1'b0;
    idle(1);
    fd0 = fd_cnt;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    en = 1'b0;
    strobe(1'b1);  // strobe coincident with disable: disable wins
    check("abandon_busy", o_busy, 0);
    strobe(1'b1);
    check("disabled_no_start_err", o_se, 0);
    idle(3);
    check("abandon_no_done", fd_cnt, fd0);
    check("abandon_p_data", o_pd, last_pd[0]);
    en = 1'b1;
    send_frame(8'hFF, 0, 0, 0, 1, 1, 0);

    // Asynchronous reset mid-frame
    send_frame(8'h81, 0, 0, 0, 1, 1, 0);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_p_data", o_pd, 0);
    check("async_rst_busy", o_busy, 0);
    check("async_rst_flags", {o_fd, o_dv, o_se, o_pe, o_ste}, 0);
    last_pd[0] = 8'h00; last_pd[1] = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h00, 0, 0, 0, 1, 1, 0);
    send_frame(8'hFF, 0, 0, 0, 1, 1, 0);  // back-to-back, no gap

    // Randomized frames on both instances
    for (int k = 0; k < 150; k++) begin
      logic [7:0] d;
      logic pen, ptyp, pbit, s0, s1;
      sel  = 1'($urandom);
      d    = 8'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      pbit = ($urandom_range(0, 3) == 0) ? ~((^d) ^ ptyp) : ((^d) ^ ptyp);
      s0   = ($urandom_range(0, 4) != 0);
      s1   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      send_frame(d, pen, ptyp, pbit, s0, s1, 1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Parametrised UART receive frame checker. It sits between the RX bit sampler and the RX output register. It consumes one sampled bit per strobe and walks the frame through a state machine: start, data LSB-first, optional parity, then 1 or 2 stop bits. It deserialises the data, checks start, parity and stop, and reports each frame with a single-cycle result pulse.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5–9.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- rx_enable  in  1  when low, the FSM returns to IDLE on the next edge; no result pulses are produced.
- bit_valid  in  1  one-cycle strobe; sampled_bit is valid in the same cycle; may assert on consecutive cycles.
- sampled_bit  in  1  majority-voted line sample.
- PAR_EN  in  1  enables the parity bit; captured at start acceptance.
- PAR_TYP  in  1  parity type, 0 = even, 1 = odd; captured at start acceptance.
- P_DATA  out  DATA_WIDTH  received data; holds until the next frame_done.
- frame_done  out  1  one-cycle pulse at the end of every frame, whether good or errored.
- data_valid  out  1  one-cycle pulse coincident with frame_done when the frame has no parity or stop error.
- start_error  out  1  one-cycle pulse when a start sample is rejected.
- parity_error  out  1  one-cycle pulse, coincident with frame_done.
- stop_error  out  1  one-cycle pulse, coincident with frame_done.
- busy  out  1  high while a frame is in progress.

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE, strobe with sampled_bit = 0:
  - Accept the start bit.
  - Capture PAR_EN and PAR_TYP.
  - Clear the shift register and the parity accumulator.
  - bit_cnt = 0; go to DATA.
- IDLE, strobe with sampled_bit = 1:
  - Treat as a false start; pulse start_error and stay in IDLE.
- DATA, each strobe:
  - Shift the bit into position bit_cnt (LSB first).
  - XOR the bit into the parity accumulator.
  - Increment bit_cnt; bit_cnt is ceil(log2(DATA_WIDTH)) bits wide.
  - On the strobe with bit_cnt = DATA_WIDTH-1, go to PARITY if parity is captured as enabled, else go to STOP.
- PARITY, one strobe:
  - Expected bit = accumulator XOR captured PAR_TYP.
  - A mismatch sets the internal parity-fail flag; go to STOP.
- STOP:
  - A strobe with sampled_bit = 0 is a stop error and ends the frame immediately, even with STOP_BITS = 2.
  - Otherwise the frame ends after STOP_BITS strobes of 1; stop_cnt is 1 bit wide.
- Frame end:
  - Pulse frame_done and load P_DATA.
  - Pulse parity_error and/or stop_error as applicable.
  - Pulse data_valid only if both are clear.
  - Return to IDLE.
- Parity is not checked when PAR_EN was captured low; parity_error stays 0.
- rx_enable low while busy abandons the frame silently: P_DATA is unchanged, no pulses, IDLE.
- rx_enable low in IDLE: strobes are ignored and no start_error is produced.
- rx_enable and bit_valid high together, with rx_enable falling this cycle: rx_enable wins.
- Changing PAR_EN or PAR_TYP mid-frame has no effect on the current frame.

## Timing
- Reset values: state = IDLE, P_DATA = 0. frame_done, data_valid, start_error, parity_error, stop_error and busy are all 0.
- Reset assertion mid-frame clears everything immediately (asynchronous).
- All outputs are registered.
- Pulses appear in the cycle after the strobe that causes them and last exactly one cycle.
- busy rises in the cycle after the accepted start strobe.
- busy falls in the same cycle frame_done is high.
- Frame length in strobes: 1 + DATA_WIDTH + PAR_EN + STOP_BITS. A stop error shortens this.
- A strobe arriving in the frame_done cycle is evaluated in IDLE, so back-to-back frames need no gap.

## Test plan
- Good frame, 8N1, data 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> P_DATA = 0xA5; frame_done and data_valid pulse one cycle after the stop strobe; all errors 0.
- Parity errors, 8E1 with data 0x03 -> expected parity bit is 0:
  - Send parity bit 1 -> parity_error = 1, data_valid = 0, P_DATA = 0x03.
  - Repeat in odd mode with parity bit 1 -> clean frame.
- False start: strobe with sampled_bit = 1 in IDLE -> start_error pulses for 1 cycle, busy stays 0; a following valid frame of 0x3C is received correctly.
- Stop errors, STOP_BITS = 2:
  - First stop bit 0 -> stop_error plus frame_done in the next cycle; the second stop strobe is treated as IDLE.
  - Stop bits 1,1 -> clean frame.
- Abandoned frame: drop rx_enable after 4 data strobes -> no pulses, P_DATA keeps its old value; re-enable and send 0xFF -> received.
- Reset mid-frame: assert Reset asynchronously mid-frame -> every output is 0 immediately; back-to-back frames 0x00 and 0xFF with no idle strobe between them are both received.
